ysyx_041461_if_pcgen: RTL and testbench
=======================================

// Module: ysyx_041461_IF_pcgen
// PURPOSE
//  Parametrised PC generator for the IF stage with a valid/ready fetch handshake.
//  Selects the next PC from trap entry (direct or vectored mtvec), mret (mepc), ID redirect or sequential step.
//  A redirect that arrives while a fetch request is still unaccepted is held in a one-deep pending slot.
//  An epoch bit tags each request so downstream stages can discard wrong-path fetches.
// PARAMETERS
//  XLEN      64            PC / CSR width in bits
//  CAUSE_W   63            width of trap cause code
//  RESET_PC  64'h3000_0000 PC value after reset
//  STEP      4             sequential increment in bytes
// PORTS
//  clk           in   1        clock, all state updates on posedge
//  rst           in   1        synchronous, active-low reset (0 = reset)
//  enable        in   1        1 = IF may issue a new request; 0 = stall (does not drop an issued request)
//  wb_ctrl       in   2        00 NOP, 01 trap to mtvec, 10 mret to mepc, 11 reserved (treated as NOP)
//  id_redirect   in   1        1 = branch/jump redirect from ID
//  id_target     in   XLEN     ID redirect target
//  mtvec         in   XLEN     trap vector CSR
//  mepc          in   XLEN     exception PC CSR
//  cause         in   CAUSE_W  trap cause code (excluding interrupt bit)
//  cause_intr    in   1        1 = trap is an interrupt
//  fetch_ready   in   1        memory accepts the current request
//  fetch_valid   out  1        request valid
//  fetch_pc      out  XLEN     request address
//  fetch_epoch   out  1        epoch tag of the request
//  redir_pend    out  1        a redirect is held in the pending slot
// BEHAVIOUR
//  Reset (rst=0): pc=RESET_PC, fetch_valid=0, fetch_epoch=0, redir_pend=0, state=BOOT.
//  FSM: BOOT -> RUN on the first cycle with rst=1; BOOT never asserts valid. RUN stays until reset.
//  fetch_valid = RUN & (enable | held); held sets when valid&~ready, clears on fire (valid&ready).
//  Once asserted, valid stays high with fetch_pc/fetch_epoch stable until fire, regardless of enable.
//  Trap target:
//   mtvec[1:0]==01 and cause_intr=1 -> {mtvec[XLEN-1:2],2'b00} + (zero-extended cause << 2), truncated to XLEN.
//   All other cases -> {mtvec[XLEN-1:2],2'b00}. Modes 10/11 are direct.
//  Redirect priority (high->low): WB this cycle, pending WB, ID this cycle, pending ID, pc+STEP.
//  Target of this-cycle redirect is computed from current inputs; the pending slot stores the computed target.
//  No outstanding request (fetch_valid=0): a redirect loads pc next cycle, toggles epoch, and leaves pending empty.
//  Outstanding, not accepted (valid&~ready): redirect is written to the pending slot.
//   A WB redirect overwrites a pending ID redirect; an ID redirect never overwrites a pending WB redirect.
//  Fire cycle: pc <= highest-priority source. Any redirect source toggles epoch, and pending is cleared.
//   With no redirect, pc <= pc+STEP, wrapping modulo 2^XLEN, and epoch is unchanged.
//  With no fire and no redirect, pc and epoch hold (enable=0 behaviour).
//  redir_pend is registered and equals slot occupancy.
//  Reset mid-request: valid drops in the same reset cycle; pending and held are cleared.
//  Latency: redirect to new fetch_pc is 1 cycle when idle, or the cycle after fire when outstanding.
// TESTING
//  1 rst=0 2 cyc, then 1, ready=1, enable=1 -> valid=0 in BOOT cycle; pc sequence 0x3000_0000, _0004, _0008; epoch=0.
//  2 Hold ready=0 3 cyc -> fetch_pc/epoch/valid stable while enable toggles 1/0/1.
//  3 Outstanding req, ready=0, id_redirect to 0x8000_0100 -> redir_pend=1.
//    Then ready=1 -> next fetch_pc=0x8000_0100, epoch toggles, redir_pend=0.
//  4 Pending ID 0x100, then wb_ctrl=10 with mepc=0x200 while stalled -> after fire pc=0x200.
//    Reverse order (WB first, then ID) -> pc=0x200.
//  5 mtvec=0x8000_0001, cause=7, cause_intr=1, trap -> pc=0x8000_001C.
//    Same with cause_intr=0 -> pc=0x8000_0000. mtvec=...03 -> 0x8000_0000.
//  6 pc=2^XLEN-4, sequential fire -> pc=0. rst=0 during outstanding pending redirect -> pc=RESET_PC, valid=0, redir_pend=0.

Source files
------------

// File: rtl/ysyx_041461_if_pcgen_if.sv
// Fetch request channel between the IF PC generator and instruction memory.
// The master issues valid/pc/epoch; the slave answers with ready.
interface ysyx_041461_if_pcgen_if #(
    parameter int XLEN = 64
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_epoch;

    modport master (
        output fetch_valid,
        output fetch_pc,
        output fetch_epoch,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_pc,
        input  fetch_epoch,
        output fetch_ready
    );
endinterface

// File: rtl/ysyx_041461_if_pcgen.sv
// IF-stage PC generator: picks trap/mret/ID-redirect/sequential next PC,
// holds requests stable until accepted, and buffers one late redirect.
module ysyx_041461_if_pcgen #(
    parameter int              XLEN     = 64,
    parameter int              CAUSE_W  = 63,
    parameter logic [XLEN-1:0] RESET_PC = 64'h3000_0000,
    parameter int              STEP     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [1:0]          wb_ctrl,
    input  logic                id_redirect,
    input  logic [XLEN-1:0]     id_target,
    input  logic [XLEN-1:0]     mtvec,
    input  logic [XLEN-1:0]     mepc,
    input  logic [CAUSE_W-1:0]  cause,
    input  logic                cause_intr,
    ysyx_041461_if_pcgen_if.master fetch,
    output logic                redir_pend
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            epoch;
    logic            held;
    logic            pend_valid;
    logic            pend_wb;
    logic [XLEN-1:0] pend_tgt;

    logic            valid;
    logic            fire;
    logic            stalled;
    logic            wb_now;
    logic            any_redir;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] cause_ext;
    logic [XLEN-1:0] trap_tgt;
    logic [XLEN-1:0] wb_tgt;
    logic [XLEN-1:0] next_pc;

    // Valid is gated by rst directly so a synchronous reset kills the request in the same cycle.
    assign valid   = (state == RUN) & rst & (enable | held);
    assign fire    = valid & fetch.fetch_ready;
    assign stalled = valid & ~fetch.fetch_ready;

    assign fetch.fetch_valid = valid;
    assign fetch.fetch_pc    = pc;
    assign fetch.fetch_epoch = epoch;
    assign redir_pend        = pend_valid;

    always_comb begin
        base      = {mtvec[XLEN-1:2], 2'b00};
        cause_ext = XLEN'(cause);
        trap_tgt  = base;
        if (mtvec[1:0] == 2'b01 && cause_intr) begin
            trap_tgt = base + (cause_ext << 2);
        end
        wb_now    = (wb_ctrl == 2'b01) || (wb_ctrl == 2'b10);
        wb_tgt    = (wb_ctrl == 2'b01) ? trap_tgt : mepc;
        any_redir = wb_now | id_redirect | pend_valid;

        // Priority: live WB, pending WB, live ID, pending ID, sequential.
        next_pc = pc + XLEN'(STEP);
        if (wb_now) begin
            next_pc = wb_tgt;
        end else if (pend_valid && pend_wb) begin
            next_pc = pend_tgt;
        end else if (id_redirect) begin
            next_pc = id_target;
        end else if (pend_valid) begin
            next_pc = pend_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            epoch      <= 1'b0;
            held       <= 1'b0;
            pend_valid <= 1'b0;
            pend_wb    <= 1'b0;
            pend_tgt   <= '0;
        end else begin
            if (state == BOOT) begin
                state <= RUN;
            end
            held <= stalled;
            if (stalled) begin
                // A pending WB redirect is never displaced by a later ID redirect.
                if (wb_now) begin
                    pend_valid <= 1'b1;
                    pend_wb    <= 1'b1;
                    pend_tgt   <= wb_tgt;
                end else if (id_redirect && !(pend_valid && pend_wb)) begin
                    pend_valid <= 1'b1;
                    pend_wb    <= 1'b0;
                    pend_tgt   <= id_target;
                end
            end else if (fire || any_redir) begin
                pc         <= next_pc;
                epoch      <= epoch ^ any_redir;
                pend_valid <= 1'b0;
                pend_wb    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_041461_if_pcgen.sv
// Scoreboard bench for the IF PC generator: expected fetches are queued as
// stimulus is applied and popped whenever the request fires.
module tb_ysyx_041461_if_pcgen;

    localparam logic [63:0] RST_PC = 64'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  wb_ctrl = 2'b00;
    logic        id_redirect = 1'b0;
    logic [63:0] id_target = '0;
    logic [63:0] mtvec = '0;
    logic [63:0] mepc = '0;
    logic [62:0] cause = '0;
    logic        cause_intr = 1'b0;
    logic        redir_pend;

    logic [64:0] q[$];
    logic [64:0] exp_val;
    int          total = 0;
    int          bad = 0;

    ysyx_041461_if_pcgen_if #(.XLEN(64)) bus ();

    ysyx_041461_if_pcgen dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .wb_ctrl     (wb_ctrl),
        .id_redirect (id_redirect),
        .id_target   (id_target),
        .mtvec       (mtvec),
        .mepc        (mepc),
        .cause       (cause),
        .cause_intr  (cause_intr),
        .fetch       (bus.master),
        .redir_pend  (redir_pend)
    );

    always #5 clk = ~clk;

    task automatic reset_and_boot(input logic en, input logic rdy);
        rst = 1'b0;
        enable = en;
        bus.fetch_ready = rdy;
        wb_ctrl = 2'b00;
        id_redirect = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b1;
        bus.fetch_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (bus.fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", bus.fetch_valid); end
        total++;
        if (bus.fetch_pc !== RST_PC) begin bad++; $display("[TB] FAIL reset_pc got=%h want=%h", bus.fetch_pc, RST_PC); end
        total++;
        if (bus.fetch_epoch !== 1'b0) begin bad++; $display("[TB] FAIL reset_epoch got=%b want=0", bus.fetch_epoch); end
        total++;
        if (redir_pend !== 1'b0) begin bad++; $display("[TB] FAIL reset_pend got=%b want=0", redir_pend); end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL boot_valid got=%b want=0", bus.fetch_valid); end
        q.push_back({1'b0, 64'h3000_0000});
        q.push_back({1'b0, 64'h3000_0004});
        q.push_back({1'b0, 64'h3000_0008});
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (!(bus.fetch_valid && bus.fetch_ready) || q.size() == 0) begin
                bad++; $display("[TB] FAIL seq_fire got=%b want=1", bus.fetch_valid);
            end else begin
                exp_val = q.pop_front();
                if ({bus.fetch_epoch, bus.fetch_pc} !== exp_val) begin
                    bad++; $display("[TB] FAIL seq_pc got=%h want=%h", {bus.fetch_epoch, bus.fetch_pc}, exp_val);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_hold();
        reset_and_boot(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            enable = (i != 1);
            @(negedge clk);
            total++;
            if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== RST_PC || bus.fetch_epoch !== 1'b0) begin
                bad++; $display("[TB] FAIL hold_stable got=%b/%h/%b want=1/%h/0",
                                bus.fetch_valid, bus.fetch_pc, bus.fetch_epoch, RST_PC);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_id_pending();
        reset_and_boot(1'b1, 1'b0);
        id_redirect = 1'b1;
        id_target = 64'h8000_0100;
        @(posedge clk);
        #1 id_redirect = 1'b0;
        bus.fetch_ready = 1'b1;
        q.push_back({1'b0, RST_PC});
        q.push_back({1'b1, 64'h8000_0100});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (redir_pend !== (i == 0)) begin
                bad++; $display("[TB] FAIL id_pend got=%b want=%b", redir_pend, (i == 0));
            end
            total++;
            if (!(bus.fetch_valid && bus.fetch_ready) || q.size() == 0) begin
                bad++; $display("[TB] FAIL id_fire got=%b want=1", bus.fetch_valid);
            end else begin
                exp_val = q.pop_front();
                if ({bus.fetch_epoch, bus.fetch_pc} !== exp_val) begin
                    bad++; $display("[TB] FAIL id_pc got=%h want=%h", {bus.fetch_epoch, bus.fetch_pc}, exp_val);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.fetch_ready = 1'b0;
    endtask

    task automatic test_wb_priority();
        for (int order = 0; order < 2; order++) begin
            reset_and_boot(1'b1, 1'b0);
            mepc = 64'h200;
            id_target = 64'h100;
            if (order == 0) id_redirect = 1'b1;
            else            wb_ctrl = 2'b10;
            @(posedge clk);
            #1;
            if (order == 0) begin id_redirect = 1'b0; wb_ctrl = 2'b10; end
            else            begin wb_ctrl = 2'b00; id_redirect = 1'b1; end
            @(posedge clk);
            #1 wb_ctrl = 2'b00;
            id_redirect = 1'b0;
            @(negedge clk);
            total++;
            if (redir_pend !== 1'b1) begin bad++; $display("[TB] FAIL prio_pend order=%0d got=%b want=1", order, redir_pend); end
            @(posedge clk);
            #1 bus.fetch_ready = 1'b1;
            q.push_back({1'b0, RST_PC});
            q.push_back({1'b1, 64'h200});
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                total++;
                if (!(bus.fetch_valid && bus.fetch_ready) || q.size() == 0) begin
                    bad++; $display("[TB] FAIL prio_fire order=%0d got=%b want=1", order, bus.fetch_valid);
                end else begin
                    exp_val = q.pop_front();
                    if ({bus.fetch_epoch, bus.fetch_pc} !== exp_val) begin
                        bad++; $display("[TB] FAIL prio_pc order=%0d got=%h want=%h", order, {bus.fetch_epoch, bus.fetch_pc}, exp_val);
                    end
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_trap();
        logic [63:0] tv_mtvec [3] = '{64'h8000_0001, 64'h8000_0001, 64'h8000_0003};
        logic        tv_intr  [3] = '{1'b1, 1'b0, 1'b1};
        logic [63:0] tv_exp   [3] = '{64'h8000_001C, 64'h8000_0000, 64'h8000_0000};
        for (int k = 0; k < 3; k++) begin
            reset_and_boot(1'b1, 1'b1);
            wb_ctrl = 2'b01;
            mtvec = tv_mtvec[k];
            cause = 63'd7;
            cause_intr = tv_intr[k];
            q.push_back({1'b0, RST_PC});
            q.push_back({1'b1, tv_exp[k]});
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                total++;
                if (!(bus.fetch_valid && bus.fetch_ready) || q.size() == 0) begin
                    bad++; $display("[TB] FAIL trap_fire case=%0d got=%b want=1", k, bus.fetch_valid);
                end else begin
                    exp_val = q.pop_front();
                    if ({bus.fetch_epoch, bus.fetch_pc} !== exp_val) begin
                        bad++; $display("[TB] FAIL trap_pc case=%0d got=%h want=%h", k, {bus.fetch_epoch, bus.fetch_pc}, exp_val);
                    end
                end
                @(posedge clk);
                #1 wb_ctrl = 2'b00;
            end
        end
    endtask

    task automatic test_wrap();
        reset_and_boot(1'b0, 1'b1);
        id_redirect = 1'b1;
        id_target = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        total++;
        if (bus.fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL idle_valid got=%b want=0", bus.fetch_valid); end
        @(posedge clk);
        #1 id_redirect = 1'b0;
        enable = 1'b1;
        q.push_back({1'b1, 64'hFFFF_FFFF_FFFF_FFFC});
        q.push_back({1'b1, 64'h0});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (!(bus.fetch_valid && bus.fetch_ready) || q.size() == 0) begin
                bad++; $display("[TB] FAIL wrap_fire got=%b want=1", bus.fetch_valid);
            end else begin
                exp_val = q.pop_front();
                if ({bus.fetch_epoch, bus.fetch_pc} !== exp_val) begin
                    bad++; $display("[TB] FAIL wrap_pc got=%h want=%h", {bus.fetch_epoch, bus.fetch_pc}, exp_val);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        reset_and_boot(1'b1, 1'b0);
        id_redirect = 1'b1;
        id_target = 64'h8000_0100;
        @(posedge clk);
        #1 id_redirect = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid got=%b want=0", bus.fetch_valid); end
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        total++;
        if (bus.fetch_pc !== RST_PC || redir_pend !== 1'b0 || bus.fetch_epoch !== 1'b0) begin
            bad++; $display("[TB] FAIL midrst_state got=%h/%b/%b want=%h/0/0", bus.fetch_pc, redir_pend, bus.fetch_epoch, RST_PC);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (bus.fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_held got=%b want=0", bus.fetch_valid); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.fetch_ready = 1'b0;
        test_reset();
        test_hold();
        test_id_pending();
        test_wb_priority();
        test_trap();
        test_wrap();
        test_reset_mid();
        total++;
        if (q.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_left got=%0d want=0", q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
